booth_sweep_controller: RTL



---
 rtl/booth_sweep_controller_if.sv | 28 ++
 rtl/booth_sweep_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/booth_sweep_controller_if.sv
// Sweep handshake and result bus for booth_sweep_controller.
// master drives the sweep request; slave (the controller) returns status and results.
interface booth_sweep_controller_if #(
    parameter int N = 4
);
    logic           start;
    logic           busy;
    logic           done;
    logic [3*N:0]   err_count;
    logic           fail_valid;
    logic [N-1:0]   fail_in1;
    logic [N-1:0]   fail_in2;
    logic [N-1:0]   fail_in3;
    logic [2*N:0]   op1;
    logic [2*N:0]   op2;

    modport master (
        output start,
        input  busy, done, err_count, fail_valid,
        input  fail_in1, fail_in2, fail_in3, op1, op2
    );

    modport slave (
        input  start,
        output busy, done, err_count, fail_valid,
        output fail_in1, fail_in2, fail_in3, op1, op2
    );
endinterface

// File: rtl/booth_sweep_controller.sv
// Exhaustive clocked checker of (a+b)*c == a*c + b*c over all signed N-bit triples.
// One iterative radix-2 Booth multiplier is shared by the three products of a triple.
// Optional macro BOOTH_FAULT_INJECT_EN adds input fault_inj, which inverts bit 0
// of op1 in a CMP cycle so the error path can be exercised.
module booth_sweep_controller #(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef BOOTH_FAULT_INJECT_EN
    input  logic                      fault_inj,
`endif
    booth_sweep_controller_if.slave   bus
);
    localparam int PW = 2 * N + 1;
    localparam int SW = $clog2(N + 1);
    localparam logic [N-1:0]  MIN_V  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  MAX_V  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0] ONE_S  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0] LAST_S = SW'(N - 1);
    localparam logic [3*N:0]  ONE_E  = {{(3*N){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, MUL, CMP} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    in1_q, in2_q, in3_q;
    logic [1:0]      sel_q;
    logic [SW-1:0]   step_q;
    logic [N:0]      m_q;
    logic [N+1:0]    a_q;
    logic [N-1:0]    q_q;
    logic            q1_q;
    logic [PW-1:0]   p0_q, p1_q, p2_q;
    logic [3*N:0]    err_q;
    logic            fv_q;
    logic [N-1:0]    f1_q, f2_q, f3_q;
    logic [PW-1:0]   op1_q, op2_q;
    logic            busy_q, done_q;

    logic            last_step, last_triple;
    logic [N+1:0]    m_ext, a_sum, a_sh;
    logic [N-1:0]    q_sh;
    logic [PW-1:0]   prod, op1_c, op2_c;
    logic            mismatch;

    assign last_step   = (step_q == LAST_S);
    assign last_triple = (in1_q == MAX_V) && (in2_q == MAX_V) && (in3_q == MAX_V);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state sequencing: three LOAD/MUL passes then one CMP per triple.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    state_d = MUL;
            MUL:     if (last_step) state_d = (sel_q == 2'd2) ? CMP : LOAD;
            CMP:     state_d = last_triple ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    // One Booth step: add/subtract M per (Q0,Q_1), then arithmetic shift of {A,Q,Q_1}.
    always_comb begin
        m_ext = {m_q[N], m_q};
        case ({q_q[0], q1_q})
            2'b10:   a_sum = a_q - m_ext;
            2'b01:   a_sum = a_q + m_ext;
            default: a_sum = a_q;
        endcase
        a_sh = {a_sum[N+1], a_sum[N+1:1]};
        q_sh = {a_sum[0], q_q[N-1:1]};
        prod = {a_sh[N:0], q_sh};
    end

    // Compare operands; the fault hook acts before both the compare and the op1 register.
    always_comb begin
`ifdef BOOTH_FAULT_INJECT_EN
        op1_c = p0_q ^ {{(PW-1){1'b0}}, fault_inj};
`else
        op1_c = p0_q;
`endif
        op2_c    = p1_q + p2_q;
        mismatch = (op1_c != op2_c);
    end

    // Datapath, triple counters and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in1_q <= '0;  in2_q <= '0;  in3_q <= '0;
            sel_q <= '0;  step_q <= '0; m_q <= '0;
            a_q <= '0;    q_q <= '0;    q1_q <= 1'b0;
            p0_q <= '0;   p1_q <= '0;   p2_q <= '0;
            err_q <= '0;  fv_q <= 1'b0;
            f1_q <= '0;   f2_q <= '0;   f3_q <= '0;
            op1_q <= '0;  op2_q <= '0;
            busy_q <= 1'b0; done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        sel_q  <= '0;
                        in1_q  <= MIN_V;
                        in2_q  <= MIN_V;
                        in3_q  <= MIN_V;
                        err_q  <= '0;
                        fv_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    case (sel_q)
                        2'd0:    m_q <= {in1_q[N-1], in1_q} + {in2_q[N-1], in2_q};
                        2'd1:    m_q <= {in1_q[N-1], in1_q};
                        default: m_q <= {in2_q[N-1], in2_q};
                    endcase
                    a_q    <= '0;
                    q_q    <= in3_q;
                    q1_q   <= 1'b0;
                    step_q <= '0;
                end
                MUL: begin
                    a_q    <= a_sh;
                    q_q    <= q_sh;
                    q1_q   <= q_q[0];
                    step_q <= step_q + ONE_S;
                    if (last_step) begin
                        case (sel_q)
                            2'd0:    p0_q <= prod;
                            2'd1:    p1_q <= prod;
                            default: p2_q <= prod;
                        endcase
                        if (sel_q != 2'd2) sel_q <= sel_q + 2'd1;
                    end
                end
                CMP: begin
                    op1_q <= op1_c;
                    op2_q <= op2_c;
                    if (mismatch) begin
                        if (err_q != '1) err_q <= err_q + ONE_E;
                        if (!fv_q) begin
                            fv_q <= 1'b1;
                            f1_q <= in1_q;
                            f2_q <= in2_q;
                            f3_q <= in3_q;
                        end
                    end
                    if (last_triple) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        // in3 wraps MAX->MIN by plain increment; carries ripple outward.
                        sel_q <= '0;
                        in3_q <= in3_q + ONE_N;
                        if (in3_q == MAX_V) begin
                            in2_q <= in2_q + ONE_N;
                            if (in2_q == MAX_V) in1_q <= in1_q + ONE_N;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fv_q;
    assign bus.fail_in1   = f1_q;
    assign bus.fail_in2   = f2_q;
    assign bus.fail_in3   = f3_q;
    assign bus.op1        = op1_q;
    assign bus.op2        = op2_q;
endmodule
